// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e      - sequencing FSM states (idle, shifting, result pulse)
//   SERIAL_SUB_W - default operand width
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle of the bit-serial subtractor.
//   start, a, b          - request and operands (master -> slave)
//   busy, done, diff,
//   borrow               - status and held result (slave -> master)
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_W
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_sub_fs_cell.sv
// fs_cell: purely combinational one-bit full subtractor.
//   x, y, bin - minuend bit, subtrahend bit, borrow-in
//   d, bout   - difference bit, borrow-out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when x<y, or when x==y and a borrow is already pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor (a - b), LSB first, one fs_cell.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - serial_sub_if slave: start/a/b in, busy/done/diff/borrow out
// Result appears WIDTH cycles after start is accepted, with a one-cycle done.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_W
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_diff;
  logic [CntW-1:0]  r_cnt;
  logic             r_br;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;

  logic w_d;
  logic w_bo;

  fs_cell u_cell (
    .x    (r_ra[0]),
    .y    (r_rb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ra     <= '0;
      r_rb     <= '0;
      r_sr     <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_ra    <= bus.a;
            r_rb    <= bus.b;
            r_sr    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_sr  <= {w_d, r_sr[WIDTH-1:1]};
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            // Last bit: publish the completed word alongside the final borrow.
            r_diff   <= {w_d, r_sr[WIDTH-1:1]};
            r_borrow <= w_bo;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 (directed) and
// WIDTH=3 (all operand pairs back-to-back).
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(3)) bus3 ();

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_sub #(.WIDTH(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  exp_t e8;
  exp_t e3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] held_diff;
  logic       held_borrow;
  bit         mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the 8-bit instance: pops on done, otherwise outputs must hold.
  always @(negedge clk) begin
    if (mon_on) begin
      check("busy_and_done8", 32'(bus8.busy & bus8.done), 0);
      if (bus8.done) begin
        check("done_expected8", 32'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          check("diff8", 32'(bus8.diff), 32'(e8.diff));
          check("borrow8", 32'(bus8.borrow), 32'(e8.borrow));
          check("latency8", cyc, e8.cyc);
          held_diff   = e8.diff;
          held_borrow = e8.borrow;
        end
      end else begin
        check("hold_diff8", 32'(bus8.diff), 32'(held_diff));
        check("hold_borrow8", 32'(bus8.borrow), 32'(held_borrow));
      end
    end
  end

  // Monitor for the 3-bit instance.
  always @(negedge clk) begin
    if (mon_on) begin
      check("busy_and_done3", 32'(bus3.busy & bus3.done), 0);
      if (bus3.done) begin
        check("done_expected3", 32'(q3.size() > 0), 1);
        if (q3.size() > 0) begin
          e3 = q3.pop_front();
          check("diff3", 32'(bus3.diff), 32'(e3.diff[2:0]));
          check("borrow3", 32'(bus3.borrow), 32'(e3.borrow));
          check("latency3", cyc, e3.cyc);
        end
      end
    end
  end

  // Issue one request; accepted on the next edge if the DUT is idle.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                        input logic bo, input bit push);
    @(posedge clk);
    #1;
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    if (push) q8.push_back('{diff: d, borrow: bo, cyc: cyc + 1 + 8});
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
  endtask

  task automatic wait_done8();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus8.done) return;
    end
    check("timeout8", 32'(bus8.done), 1);
  endtask

  task automatic start3(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] full;
    full = {1'b0, a} - {1'b0, b};
    @(posedge clk);
    #1;
    bus3.start = 1'b1;
    bus3.a     = a;
    bus3.b     = b;
    q3.push_back('{diff: {5'd0, full[2:0]}, borrow: full[3], cyc: cyc + 1 + 3});
    @(posedge clk);
    #1;
    bus3.start = 1'b0;
    bus3.a     = 3'($urandom);
    bus3.b     = 3'($urandom);
  endtask

  task automatic wait_done3();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus3.done) return;
    end
    check("timeout3", 32'(bus3.done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus3.start = 1'b0;
    bus3.a     = '0;
    bus3.b     = '0;
    held_diff   = '0;
    held_borrow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 0);
    check("rst_done", 32'(bus8.done), 0);
    check("rst_diff", 32'(bus8.diff), 0);
    check("rst_borrow", 32'(bus8.borrow), 0);
    mon_on = 1'b1;

    // Basic and boundary operands.
    start8(8'h05, 8'h03, 8'h02, 1'b0, 1'b1);
    wait_done8();
    start8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1);
    wait_done8();
    repeat (4) @(negedge clk);
    start8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
    wait_done8();
    repeat (5) @(negedge clk);

    // start during SHIFT and during DONE must be ignored.
    start8(8'h05, 8'h03, 8'h02, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus8.start = 1'b1;
    bus8.a     = 8'h10;
    bus8.b     = 8'h01;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    wait_done8();
    bus8.start = 1'b1;
    bus8.a     = 8'h10;
    bus8.b     = 8'h01;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("no_restart_busy", 32'(bus8.busy), 0);
    end

    // Reset four cycles into a run discards it.
    start8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    held_diff   = '0;
    held_borrow = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus8.busy), 0);
    check("midrst_done", 32'(bus8.done), 0);
    check("midrst_diff", 32'(bus8.diff), 0);
    check("midrst_borrow", 32'(bus8.borrow), 0);
    repeat (14) @(negedge clk);
    start8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b1);
    wait_done8();
    repeat (3) @(negedge clk);

    // Reset wins over start on the same edge.
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus8.start = 1'b1;
    bus8.a     = 8'h05;
    bus8.b     = 8'h03;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus8.start  = 1'b0;
    held_diff   = '0;
    held_borrow = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rst_start_busy", 32'(bus8.busy), 0);
    end

    // WIDTH=3: every operand pair, each started right after the previous done.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        start3(3'(a), 3'(b));
        wait_done3();
      end
    end
    repeat (4) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 0);
    check("q3_drained", 32'(q3.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
